// File: rtl/cmd_pkg.sv
// Shared types and constants for the command dispatcher: FSM state encoding,
// default NAK reply byte and the opcode assigned to each handler slot.
package cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_NAK     = 2'd3
  } state_e;

  localparam logic [7:0] NAK_BYTE_DEFAULT = 8'hEE;

  localparam logic [7:0] OPC_SLOT0 = 8'h00;
  localparam logic [7:0] OPC_SLOT1 = 8'h01;
  localparam logic [7:0] OPC_SLOT2 = 8'h02;
  localparam logic [7:0] OPC_SLOT3 = 8'h03;

  // Opcode k selects handler slot k; anything at or above the slot count is invalid.
  function automatic logic [7:0] opc_for_slot(input int slot);
    return 8'(slot);
  endfunction

  function automatic logic opc_valid(input logic [7:0] opc, input int n_slots);
    return ({24'd0, opc} < 32'(n_slots));
  endfunction

endpackage

// File: rtl/cmd_watchdog.sv
// Saturating inactivity counter: expire_o holds once TIMEOUT_CYCLES-1 idle
// cycles have been counted, until cleared.
module cmd_watchdog #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int              CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == LAST);

  // Clear has priority so activity in the expiring cycle still restarts the count.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && !expire_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cmd_dispatch.sv
// Command dispatcher: decodes opcode bytes, grants the shared UART transmitter
// to one handler at a time and aborts handlers that stall past the watchdog.
//
// state   | meaning
// IDLE    | waiting for a new rx byte to decode
// RUN     | handler sel activated, its tx stream routed to the UART
// RELEASE | activate dropped, waiting for done[sel] and rx_ready to clear
// NAK     | invalid opcode, one NAK byte sent once the transmitter is free
module cmd_dispatch
  import cmd_pkg::*;
#(
  parameter int         N_HANDLERS     = 4,
  parameter int         TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0] NAK_BYTE       = NAK_BYTE_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    rx_ready_i,
  input  logic [7:0]              rx_data_i,
  input  logic                    tx_active_i,
  input  logic                    tx_done_i,
  output logic [7:0]              tx_data_o,
  output logic                    tx_start_o,
  output logic [N_HANDLERS-1:0]   hnd_activate_o,
  input  logic [N_HANDLERS-1:0]   hnd_done_i,
  input  logic [8*N_HANDLERS-1:0] hnd_tx_data_i,
  input  logic [N_HANDLERS-1:0]   hnd_tx_start_i,
  output logic                    busy_o,
  output logic                    err_o,
  output logic [7:0]              cur_cmd_o
);

  localparam int SEL_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;

  state_e                state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [7:0]            cur_cmd_q;
  logic [N_HANDLERS-1:0] activate_q;
  logic                  err_q;
  logic                  rx_ready_q;

  logic new_byte;
  logic sel_done;
  logic sel_tx_start;
  logic wd_enable;
  logic wd_clear;
  logic wd_expire;

  assign new_byte     = rx_ready_i & ~rx_ready_q;
  assign sel_done     = hnd_done_i[sel_q];
  assign sel_tx_start = hnd_tx_start_i[sel_q];
  assign wd_enable    = (state_q == ST_RUN);
  // Held clear outside RUN so every dispatch starts from zero.
  assign wd_clear     = ~wd_enable | sel_tx_start | tx_done_i;

  cmd_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (wd_clear),
    .enable_i(wd_enable),
    .expire_o(wd_expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      cur_cmd_q  <= 8'h00;
      activate_q <= '0;
      err_q      <= 1'b0;
      rx_ready_q <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready_i;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (new_byte) begin
            if (opc_valid(rx_data_i, N_HANDLERS)) begin
              sel_q      <= rx_data_i[SEL_W-1:0];
              cur_cmd_q  <= rx_data_i;
              activate_q <= N_HANDLERS'(1) << rx_data_i[SEL_W-1:0];
              state_q    <= ST_RUN;
            end else begin
              state_q <= ST_NAK;
            end
          end
        end
        ST_RUN: begin
          // A handler finishing in the expiry cycle is a normal completion.
          if (sel_done) begin
            activate_q <= '0;
            state_q    <= ST_RELEASE;
          end else if (wd_expire) begin
            activate_q <= '0;
            err_q      <= 1'b1;
            state_q    <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!sel_done && !rx_ready_i) begin
            state_q <= ST_IDLE;
          end
        end
        ST_NAK: begin
          if (!tx_active_i) begin
            state_q <= ST_RELEASE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx_data_o  = 8'h00;
    tx_start_o = 1'b0;
    if (state_q == ST_RUN) begin
      tx_data_o  = hnd_tx_data_i[{sel_q, 3'b000} +: 8];
      tx_start_o = sel_tx_start;
    end else if ((state_q == ST_NAK) && !tx_active_i) begin
      tx_data_o  = NAK_BYTE;
      tx_start_o = 1'b1;
    end
  end

  assign hnd_activate_o = activate_q;
  assign busy_o         = (state_q != ST_IDLE);
  assign err_o          = err_q;
  assign cur_cmd_o      = cur_cmd_q;

endmodule

// File: tb/tb_cmd_dispatch.sv
// Randomized directed bench for cmd_dispatch: each transaction's expected
// outputs are derived region by region from the dispatch rules.
`timescale 1ns/1ps
module tb_cmd_dispatch;
  import cmd_pkg::*;

  localparam int         N    = 4;
  localparam int         TO   = 16;
  localparam logic [7:0] NAKB = 8'hEE;

  logic           clk_i = 1'b0;
  logic           rst_ni;
  logic           rx_ready_i;
  logic [7:0]     rx_data_i;
  logic           tx_active_i;
  logic           tx_done_i;
  logic [7:0]     tx_data_o;
  logic           tx_start_o;
  logic [N-1:0]   hnd_activate_o;
  logic [N-1:0]   hnd_done_i;
  logic [8*N-1:0] hnd_tx_data_i;
  logic [N-1:0]   hnd_tx_start_i;
  logic           busy_o;
  logic           err_o;
  logic [7:0]     cur_cmd_o;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] last_cmd = 8'h00;

  cmd_dispatch #(
    .N_HANDLERS(N), .TIMEOUT_CYCLES(TO), .NAK_BYTE(NAKB)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rx_ready_i(rx_ready_i), .rx_data_i(rx_data_i),
    .tx_active_i(tx_active_i), .tx_done_i(tx_done_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o),
    .hnd_activate_o(hnd_activate_o), .hnd_done_i(hnd_done_i),
    .hnd_tx_data_i(hnd_tx_data_i), .hnd_tx_start_i(hnd_tx_start_i),
    .busy_o(busy_o), .err_o(err_o), .cur_cmd_o(cur_cmd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk_i);
    #1;
  endtask

  task automatic quiet();
    hnd_done_i     = '0;
    hnd_tx_start_i = '0;
    hnd_tx_data_i  = '0;
    tx_done_i      = 1'b0;
    tx_active_i    = 1'b0;
  endtask

  // Random traffic from every handler except k; none of it may leak through.
  task automatic junk(input int k);
    logic [N-1:0] mask;
    mask           = N'(1) << k;
    hnd_tx_data_i  = $urandom;
    hnd_tx_start_i = N'($urandom) & ~mask;
    hnd_done_i     = N'($urandom) & ~mask;
    tx_active_i    = 1'($urandom);
    tx_done_i      = 1'b0;
  endtask

  function automatic logic [7:0] hdata(input int k);
    return hnd_tx_data_i[8*k +: 8];
  endfunction

  task automatic check_run(input int k, input logic exp_start);
    #1;
    check("act_run",      32'(hnd_activate_o), 32'(N'(1) << k));
    check("busy_run",     32'(busy_o), 32'd1);
    check("err_run",      32'(err_o), 32'd0);
    check("cur_cmd_run",  32'(cur_cmd_o), 32'(last_cmd));
    check("tx_start_run", 32'(tx_start_o), 32'(exp_start));
    check("tx_data_run",  32'(tx_data_o), 32'(hdata(k)));
  endtask

  task automatic run_cmd(input int k, input int nbytes);
    int gap, hold_done, hold_rx, rel_len;
    quiet();
    rx_ready_i = 1'b1;
    rx_data_i  = opc_for_slot(k);
    #1;
    check("idle_busy", 32'(busy_o), 32'd0);
    last_cmd = opc_for_slot(k);
    nxt(); junk(k); check_run(k, 1'b0);
    for (int b = 0; b <= nbytes; b++) begin
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        nxt(); junk(k);
        tx_done_i  = 1'($urandom);
        rx_ready_i = 1'($urandom);
        rx_data_i  = 8'($urandom);
        check_run(k, 1'b0);
      end
      if (b < nbytes) begin
        nxt(); junk(k);
        hnd_tx_start_i[k] = 1'b1;
        check_run(k, 1'b1);
      end
    end
    nxt(); junk(k);
    hnd_done_i[k] = 1'b1;
    check_run(k, 1'b0);
    hold_done = $urandom_range(0, 2);
    hold_rx   = $urandom_range(0, 2);
    rel_len   = ((hold_done > hold_rx) ? hold_done : hold_rx) + 1;
    for (int j = 1; j <= rel_len + 1; j++) begin
      nxt(); junk(k);
      hnd_tx_start_i[k] = 1'($urandom);
      hnd_done_i[k]     = (j <= hold_done);
      rx_ready_i        = (j <= hold_rx);
      #1;
      check("act_rel",      32'(hnd_activate_o), 32'd0);
      check("err_rel",      32'(err_o), 32'd0);
      check("tx_start_rel", 32'(tx_start_o), 32'd0);
      check("busy_rel",     32'(busy_o), 32'(j <= rel_len));
      check("cur_cmd_rel",  32'(cur_cmd_o), 32'(last_cmd));
    end
  endtask

  // mode 1: handler hangs; mode 2: done arrives in the expiry cycle.
  task automatic run_hang(input int k, input int mode);
    quiet();
    rx_ready_i = 1'b1;
    rx_data_i  = opc_for_slot(k);
    #1;
    check("hang_idle_busy", 32'(busy_o), 32'd0);
    last_cmd = opc_for_slot(k);
    for (int j = 0; j < TO; j++) begin
      nxt(); junk(k);
      rx_ready_i = (j == 0);
      if (mode == 2 && j == TO - 1) hnd_done_i[k] = 1'b1;
      check_run(k, 1'b0);
    end
    nxt(); junk(k);
    rx_ready_i = 1'b0;
    #1;
    check("hang_act",      32'(hnd_activate_o), 32'd0);
    check("hang_err",      32'(err_o), 32'(mode == 1));
    check("hang_busy",     32'(busy_o), 32'd1);
    check("hang_tx_start", 32'(tx_start_o), 32'd0);
    nxt(); junk(k);
    #1;
    check("hang_err_end",  32'(err_o), 32'd0);
    check("hang_busy_end", 32'(busy_o), 32'd0);
    check("hang_act_end",  32'(hnd_activate_o), 32'd0);
  endtask

  task automatic run_nak(input logic [7:0] op);
    int act_len;
    act_len = $urandom_range(0, 4);
    quiet();
    rx_ready_i = 1'b1;
    rx_data_i  = op;
    #1;
    check("nak_idle_busy", 32'(busy_o), 32'd0);
    for (int j = 0; j <= act_len; j++) begin
      nxt(); quiet();
      hnd_tx_start_i = N'($urandom);
      hnd_tx_data_i  = $urandom;
      tx_active_i    = (j < act_len);
      #1;
      check("nak_tx_start", 32'(tx_start_o), 32'(j == act_len));
      check("nak_tx_data",  32'(tx_data_o), (j == act_len) ? 32'(NAKB) : 32'd0);
      check("nak_act",      32'(hnd_activate_o), 32'd0);
      check("nak_busy",     32'(busy_o), 32'd1);
      check("nak_err",      32'(err_o), 32'd0);
      check("nak_cur_cmd",  32'(cur_cmd_o), 32'(last_cmd));
    end
    nxt(); quiet();
    rx_ready_i  = 1'b0;
    tx_active_i = 1'($urandom);
    #1;
    check("nak_rel_busy",     32'(busy_o), 32'd1);
    check("nak_rel_tx_start", 32'(tx_start_o), 32'd0);
    nxt(); quiet();
    #1;
    check("nak_end_busy",    32'(busy_o), 32'd0);
    check("nak_end_cur_cmd", 32'(cur_cmd_o), 32'(last_cmd));
  endtask

  initial begin
    int k;
    rst_ni     = 1'b0;
    rx_ready_i = 1'b0;
    rx_data_i  = 8'h00;
    quiet();
    nxt(); nxt();
    #1;
    check("rst_tx_data",  32'(tx_data_o), 32'd0);
    check("rst_tx_start", 32'(tx_start_o), 32'd0);
    check("rst_act",      32'(hnd_activate_o), 32'd0);
    check("rst_busy",     32'(busy_o), 32'd0);
    check("rst_err",      32'(err_o), 32'd0);
    check("rst_cur_cmd",  32'(cur_cmd_o), 32'd0);
    rst_ni = 1'b1;

    run_cmd(0, 3);
    run_nak(8'h07);
    run_hang(2, 1);
    run_cmd(1, 2);
    for (int i = 0; i < 14; i++) begin
      k = $urandom_range(0, N - 1);
      case ($urandom_range(0, 3))
        0, 1:    run_cmd(k, $urandom_range(0, 4));
        2:       run_nak(8'($urandom_range(N, 255)));
        default: run_hang(k, $urandom_range(1, 2));
      endcase
    end
    run_hang(3, 2);

    // Asynchronous reset between clock edges while handler 2 is transmitting.
    quiet();
    rx_ready_i = 1'b1;
    rx_data_i  = opc_for_slot(2);
    last_cmd   = opc_for_slot(2);
    nxt(); quiet();
    hnd_tx_data_i     = $urandom;
    hnd_tx_start_i[2] = 1'b1;
    #1;
    check("pre_rst_tx_start", 32'(tx_start_o), 32'd1);
    check("pre_rst_act",      32'(hnd_activate_o), 32'd4);
    #1;
    rst_ni = 1'b0;
    #1;
    check("async_rst_act",      32'(hnd_activate_o), 32'd0);
    check("async_rst_tx_start", 32'(tx_start_o), 32'd0);
    check("async_rst_busy",     32'(busy_o), 32'd0);
    check("async_rst_cur_cmd",  32'(cur_cmd_o), 32'd0);
    last_cmd   = 8'h00;
    rx_ready_i = 1'b0;
    quiet();
    nxt(); nxt();
    rst_ni = 1'b1;
    run_cmd(0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
